felixfeierabend_mux: RTL and testbench

Registered eight-way function multiplexer that forms the Tiny Tapeout user tile top level. `ui_in[2:0]` selects one of eight 8-bit sources, which are all derived from `uio_in` or from internal state. The selected source is registered onto `uo_out`. The bidirectional bus is used only as an input.

---
 rtl/felixfeierabend_pkg.sv | 53 +++++
 rtl/felixfeierabend_lfsr8.sv | 31 +++
 rtl/felixfeierabend_mux.sv | 110 +++++++++++
 tb/tb_felixfeierabend_mux.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/felixfeierabend_pkg.sv
// Purpose : shared select encodings, LFSR constants and small data helpers for the mux tile.
// Latency : n/a (types, constants and pure functions only).
// Backpr. : n/a.
package felixfeierabend_pkg;

    // Source select encodings carried on ui_in[2:0].
    typedef enum logic [2:0] {
        SEL_PASS = 3'd0,  // D
        SEL_INV  = 3'd1,  // ~D
        SEL_CNT  = 3'd2,  // free-running counter
        SEL_REV  = 3'd3,  // D bit-reversed
        SEL_ROT  = 3'd4,  // D rotated left by rot
        SEL_ADD  = 3'd5,  // D + cnt, carry dropped
        SEL_HOLD = 3'd6,  // capture register
        SEL_LFSR = 3'd7   // LFSR state
    } sel_t;

    // LFSR reset state; must be non-zero or the register locks up.
    localparam logic [7:0] LFSR_SEED = 8'h01;

    // Feedback taps x^8 + x^6 + x^5 + x^4 + 1 (maximal length, period 255).
    localparam int unsigned LFSR_TAP0 = 7;
    localparam int unsigned LFSR_TAP1 = 5;
    localparam int unsigned LFSR_TAP2 = 4;
    localparam int unsigned LFSR_TAP3 = 3;

    localparam logic [7:0] LFSR_TAP_MASK = (8'h01 << LFSR_TAP0) | (8'h01 << LFSR_TAP1)
                                         | (8'h01 << LFSR_TAP2) | (8'h01 << LFSR_TAP3);

    // One Fibonacci step: shift left, feedback XOR of the tapped bits enters at bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAP_MASK)};
    endfunction

    // Bit i of the input lands on bit 7-i of the result.
    function automatic logic [7:0] bit_rev8(input logic [7:0] d);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[7-i];
        end
        return r;
    endfunction

    // Rotate left by 0..7. Duplicating the byte turns the rotate into a plain
    // shift whose upper half is the answer; amount 0 returns d unchanged.
    function automatic logic [7:0] rotl8(input logic [7:0] d, input logic [2:0] amt);
        logic [15:0] t;
        t = {d, d} << amt;
        return t[15:8];
    endfunction

endpackage

// File: rtl/felixfeierabend_lfsr8.sv
// Purpose : 8-bit Fibonacci LFSR, taps {7,5,4,3}, seeded to LFSR_SEED on reset.
// Latency : q is the registered state; advances one step per rising edge with en=1.
// Backpr. : none; en=0 simply holds the state.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, loads LFSR_SEED
//   en    - advance enable
//   q     - current LFSR state
module felixfeierabend_lfsr8
    import felixfeierabend_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LFSR_SEED;
        end else if (en) begin
            state <= lfsr_next(state);
        end
    end

    assign q = state;

endmodule

// File: rtl/felixfeierabend_mux.sv
// Purpose : registered eight-way function mux, Tiny Tapeout user tile top level.
// Latency : one cycle; inputs sampled at edge N are visible on uo_out after edge N.
// Backpr. : none; ena=0 freezes every register, there is no handshake.
//
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   ena        - tile enable, all state holds while low
//   ui_in      - [2:0] sel, [5:3] rot, [6] freeze (counter/LFSR hold), [7] hold load
//   uio_in     - data operand D
//   uo_out     - registered mux result
//   uio_out    - tied 0x00
//   uio_oe     - tied 0x00, uio pins are inputs only
module felixfeierabend_mux
    import felixfeierabend_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // ---------------------------------------------------------------
    // Control field decode
    // ---------------------------------------------------------------
    sel_t       sel;
    logic [2:0] rot;
    logic       freeze;
    logic       load;
    logic [7:0] d;

    assign sel    = sel_t'(ui_in[2:0]);
    assign rot    = ui_in[5:3];
    assign freeze = ui_in[6];
    assign load   = ui_in[7];
    assign d      = uio_in;

    // Counter and LFSR share one advance condition so they stay in lock-step.
    logic run;
    assign run = ena & ~freeze;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [7:0] cnt;
    logic [7:0] hold;
    logic [7:0] lfsr;
    logic [7:0] out_q;
    logic [7:0] mux_dat;

    // Wraps 0xFF -> 0x00 through natural 8-bit overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'h00;
        end else if (run) begin
            cnt <= cnt + 8'h01;
        end
    end

    // Load is independent of freeze; only ena gates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= 8'h00;
        end else if (ena && load) begin
            hold <= d;
        end
    end

    felixfeierabend_lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .q     (lfsr)
    );

    // ---------------------------------------------------------------
    // Source mux. Every source sees the pre-update value of cnt, hold
    // and lfsr, so a load with sel=HOLD shows the old capture first.
    // ---------------------------------------------------------------
    always_comb begin
        mux_dat = 8'h00;
        case (sel)
            SEL_PASS: mux_dat = d;
            SEL_INV:  mux_dat = ~d;
            SEL_CNT:  mux_dat = cnt;
            SEL_REV:  mux_dat = bit_rev8(d);
            SEL_ROT:  mux_dat = rotl8(d, rot);
            SEL_ADD:  mux_dat = d + cnt;
            SEL_HOLD: mux_dat = hold;
            SEL_LFSR: mux_dat = lfsr;
            default:  mux_dat = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 8'h00;
        end else if (ena) begin
            out_q <= mux_dat;
        end
    end

    assign uo_out  = out_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_felixfeierabend_mux.sv
// Purpose : directed self-checking bench for felixfeierabend_mux.
// Latency : inputs change 1 time unit after a rising edge; outputs sampled there too.
// Backpr. : n/a.
module tb_felixfeierabend_mux;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_chk = 0;
    int n_bad = 0;

    felixfeierabend_mux dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ui_in packing: {load, freeze, rot[2:0], sel[2:0]}
    function automatic logic [7:0] ctl(input logic ld, input logic frz,
                                       input logic [2:0] r, input logic [2:0] s);
        return {ld, frz, r, s};
    endfunction

    localparam logic [7:0] LFSR_EXP [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};

    initial begin
        // ---------------- reset with arbitrary inputs ----------------
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'hFF;
        uio_in = 8'h5A;
        step();
        step();
        chk("rst_uo_out", uo_out, 8'h00);
        chk("rst_uio_out", uio_out, 8'h00);
        chk("rst_uio_oe", uio_oe, 8'h00);

        // ---------------- LFSR sequence after release ----------------
        ui_in = ctl(1'b0, 1'b0, 3'd0, 3'd7);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("lfsr_%0d", i + 1), uo_out, LFSR_EXP[i]);
        end

        // ---------------- pass / invert / reverse ----------------
        uio_in = 8'h01;
        ui_in  = ctl(1'b0, 1'b0, 3'd0, 3'd0);
        step();
        chk("pass", uo_out, 8'h01);
        ui_in = ctl(1'b0, 1'b0, 3'd0, 3'd1);
        #2;
        chk("inv_not_yet", uo_out, 8'h01);
        step();
        chk("inv", uo_out, 8'hFE);
        ui_in = ctl(1'b0, 1'b0, 3'd0, 3'd3);
        step();
        chk("rev", uo_out, 8'h80);

        // ---------------- rotate ----------------
        uio_in = 8'h81;
        ui_in  = ctl(1'b0, 1'b0, 3'd1, 3'd4);
        step();
        chk("rot1", uo_out, 8'h03);
        ui_in = ctl(1'b0, 1'b0, 3'd4, 3'd4);
        step();
        chk("rot4", uo_out, 8'h18);
        ui_in = ctl(1'b0, 1'b0, 3'd0, 3'd4);
        step();
        chk("rot0", uo_out, 8'h81);

        // ---------------- async reset mid-operation ----------------
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", uo_out, 8'h00);
        ui_in  = ctl(1'b0, 1'b0, 3'd0, 3'd2);
        uio_in = 8'h00;
        #1;
        rst_n = 1'b1;

        // ---------------- counter, freeze, add ----------------
        step();
        chk("cnt_0", uo_out, 8'h00);
        step();
        chk("cnt_1", uo_out, 8'h01);
        ui_in = ctl(1'b0, 1'b1, 3'd0, 3'd2);         // freeze, cnt sits at 2
        step();
        chk("cnt_frz_a", uo_out, 8'h02);
        step();
        chk("cnt_frz_b", uo_out, 8'h02);
        uio_in = 8'hFF;
        ui_in  = ctl(1'b0, 1'b1, 3'd0, 3'd5);        // 0xFF + 0x02 wraps to 0x01
        step();
        chk("add_wrap", uo_out, 8'h01);
        ui_in = ctl(1'b0, 1'b0, 3'd0, 3'd2);
        step();
        chk("cnt_resume", uo_out, 8'h02);
        for (int i = 3; i <= 255; i++) begin
            step();
        end
        chk("cnt_ff", uo_out, 8'hFF);
        step();
        chk("cnt_wrap0", uo_out, 8'h00);
        step();
        chk("cnt_wrap1", uo_out, 8'h01);            // cnt now 2

        // ---------------- hold register ----------------
        uio_in = 8'hA5;
        ui_in  = ctl(1'b1, 1'b0, 3'd0, 3'd0);        // load A5 (cnt -> 3)
        step();
        uio_in = 8'h3C;
        ui_in  = ctl(1'b0, 1'b0, 3'd0, 3'd6);
        step();                                      // cnt -> 4
        chk("hold_a", uo_out, 8'hA5);
        step();                                      // cnt -> 5
        chk("hold_b", uo_out, 8'hA5);
        ui_in = ctl(1'b1, 1'b0, 3'd0, 3'd6);         // load 3C while showing hold
        step();                                      // cnt -> 6
        chk("hold_old", uo_out, 8'hA5);
        uio_in = 8'h00;
        ui_in  = ctl(1'b0, 1'b0, 3'd0, 3'd6);
        step();                                      // cnt -> 7
        chk("hold_new", uo_out, 8'h3C);

        // ---------------- enable ----------------
        ui_in = ctl(1'b0, 1'b0, 3'd0, 3'd2);
        step();                                      // shows 7, cnt -> 8
        chk("ena_pre", uo_out, 8'h07);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ui_in  = 8'h80 | 8'(i * 37);             // includes load and varied sel
            uio_in = 8'hEE ^ 8'(i);
            step();
            chk($sformatf("ena_off_%0d", i), uo_out, 8'h07);
        end
        ena    = 1'b1;
        uio_in = 8'h00;
        ui_in  = ctl(1'b0, 1'b0, 3'd0, 3'd2);
        step();
        chk("ena_resume_a", uo_out, 8'h08);
        step();
        chk("ena_resume_b", uo_out, 8'h09);
        ui_in = ctl(1'b0, 1'b0, 3'd0, 3'd6);
        step();
        chk("ena_hold_kept", uo_out, 8'h3C);
        chk("uio_out_const", uio_out, 8'h00);
        chk("uio_oe_const", uio_oe, 8'h00);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
